// File: rtl/fft_pkg.sv
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared widths, Q-format constants and round/saturate helper for
//           the SDF FFT datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int FFT_DATA_WIDTH = 16;
    localparam int FFT_TW_WIDTH   = 16;

    // Working width of sat_round; must exceed DATA_WIDTH+TW_WIDTH+2.
    localparam int ACC_W = 64;

    localparam logic signed [FFT_TW_WIDTH-1:0] ONE_Q       = FFT_TW_WIDTH'((1 << (FFT_TW_WIDTH-1)) - 1);
    localparam logic signed [FFT_TW_WIDTH-1:0] MINUS_ONE_Q = FFT_TW_WIDTH'(1 << (FFT_TW_WIDTH-1));

    localparam int SAT_MAX = (1 << (FFT_DATA_WIDTH-1)) - 1;
    localparam int SAT_MIN = -(1 << (FFT_DATA_WIDTH-1));

    typedef struct packed {
        logic                    ovf;
        logic signed [ACC_W-1:0] value;
    } sat_res_t;

    // Round half toward +inf by 'shift' bits, then range-check against a
    // signed 'width'-bit field; clamps when sat=1, otherwise leaves the value
    // for the caller to truncate.
    function automatic sat_res_t sat_round(
        input logic signed [ACC_W-1:0] value,
        input int                      shift,
        input int                      width,
        input logic                    sat
    );
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] rnd;
        logic signed [ACC_W-1:0] maxv;
        logic signed [ACC_W-1:0] minv;
        sat_res_t                res;
        bias = (shift > 0) ? (ACC_W'(1) << (shift - 1)) : ACC_W'(0);
        rnd  = (value + bias) >>> shift;
        maxv = (ACC_W'(1) << (width - 1)) - ACC_W'(1);
        minv = -maxv - ACC_W'(1);
        res.ovf   = (rnd > maxv) || (rnd < minv);
        res.value = rnd;
        if (sat && (rnd > maxv)) begin
            res.value = maxv;
        end else if (sat && (rnd < minv)) begin
            res.value = minv;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmult_pipe.sv
// ============================================================================
// Module  : cmult_pipe
// Brief   : Registered full-precision complex multiplier p = a * b.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cmult_pipe #(
    parameter int A_W = 17,
    parameter int B_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [A_W-1:0]    ar,
    input  logic signed [A_W-1:0]    ai,
    input  logic signed [B_W-1:0]    br,
    input  logic signed [B_W-1:0]    bi,
    output logic signed [A_W+B_W:0]  pr,
    output logic signed [A_W+B_W:0]  pi
);

    localparam int P_W = A_W + B_W + 1;

    logic signed [P_W-1:0] w_ar;
    logic signed [P_W-1:0] w_ai;
    logic signed [P_W-1:0] w_br;
    logic signed [P_W-1:0] w_bi;

    assign w_ar = P_W'(ar);
    assign w_ai = P_W'(ai);
    assign w_br = P_W'(br);
    assign w_bi = P_W'(bi);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pr <= '0;
            pi <= '0;
        end else if (en) begin
            pr <= (w_ar * w_br) - (w_ai * w_bi);
            pi <= (w_ar * w_bi) + (w_ai * w_br);
        end
    end

endmodule

`default_nettype wire

// File: rtl/butterfly_r2_pipe.sv
// ============================================================================
// Module  : butterfly_r2_pipe
// Brief   : 3-stage radix-2 DIF butterfly: sum = a+b, diff = (a-b)*W with
//           optional /2 scaling, rounding, saturation and overflow flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module butterfly_r2_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int TW_WIDTH   = FFT_TW_WIDTH,
    parameter int SAT_EN     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] in1_r,
    input  logic signed [DATA_WIDTH-1:0] in1_i,
    input  logic signed [DATA_WIDTH-1:0] in2_r,
    input  logic signed [DATA_WIDTH-1:0] in2_i,
    input  logic signed [TW_WIDTH-1:0]   tw_r,
    input  logic signed [TW_WIDTH-1:0]   tw_i,
    input  logic                         ovf_clr,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] sum_out_r,
    output logic signed [DATA_WIDTH-1:0] sum_out_i,
    output logic signed [DATA_WIDTH-1:0] diff_out_r,
    output logic signed [DATA_WIDTH-1:0] diff_out_i,
    output logic                         ovf,
    output logic                         ovf_sticky
);

    localparam int   SW  = DATA_WIDTH + 1;
    localparam int   PW  = DATA_WIDTH + TW_WIDTH + 2;
    localparam logic SAT = (SAT_EN != 0);

    // Stage 1: full-precision sum/difference
    logic signed [SW-1:0]       r_s1_sr, r_s1_si, r_s1_dr, r_s1_di;
    logic signed [TW_WIDTH-1:0] r_s1_twr, r_s1_twi;
    logic                       r_s1_scale, r_s1_v;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_sr    <= '0;
            r_s1_si    <= '0;
            r_s1_dr    <= '0;
            r_s1_di    <= '0;
            r_s1_twr   <= '0;
            r_s1_twi   <= '0;
            r_s1_scale <= 1'b0;
            r_s1_v     <= 1'b0;
        end else if (en) begin
            r_s1_sr    <= SW'(in1_r) + SW'(in2_r);
            r_s1_si    <= SW'(in1_i) + SW'(in2_i);
            r_s1_dr    <= SW'(in1_r) - SW'(in2_r);
            r_s1_di    <= SW'(in1_i) - SW'(in2_i);
            r_s1_twr   <= tw_r;
            r_s1_twi   <= tw_i;
            r_s1_scale <= scale;
            r_s1_v     <= in_valid;
        end
    end

    // Stage 2: twiddle multiply, sum path delayed to match
    logic signed [PW-1:0] w_pr, w_pi;
    logic signed [SW-1:0] r_s2_sr, r_s2_si;
    logic                 r_s2_scale, r_s2_v;

    cmult_pipe #(
        .A_W (SW),
        .B_W (TW_WIDTH)
    ) u_cmult (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .ar  (r_s1_dr),
        .ai  (r_s1_di),
        .br  (r_s1_twr),
        .bi  (r_s1_twi),
        .pr  (w_pr),
        .pi  (w_pi)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_sr    <= '0;
            r_s2_si    <= '0;
            r_s2_scale <= 1'b0;
            r_s2_v     <= 1'b0;
        end else if (en) begin
            r_s2_sr    <= r_s1_sr;
            r_s2_si    <= r_s1_si;
            r_s2_scale <= r_s1_scale;
            r_s2_v     <= r_s1_v;
        end
    end

    // Stage 3: round, reduce width, flag overflow
    int       w_sum_sh, w_prod_sh;
    sat_res_t w_res_sr, w_res_si, w_res_dr, w_res_di;
    logic     w_ovf_any, w_sticky_set, w_unused;

    assign w_sum_sh  = r_s2_scale ? 1 : 0;
    assign w_prod_sh = r_s2_scale ? TW_WIDTH : TW_WIDTH - 1;

    assign w_res_sr = sat_round(ACC_W'(r_s2_sr), w_sum_sh,  DATA_WIDTH, SAT);
    assign w_res_si = sat_round(ACC_W'(r_s2_si), w_sum_sh,  DATA_WIDTH, SAT);
    assign w_res_dr = sat_round(ACC_W'(w_pr),    w_prod_sh, DATA_WIDTH, SAT);
    assign w_res_di = sat_round(ACC_W'(w_pi),    w_prod_sh, DATA_WIDTH, SAT);

    assign w_ovf_any = w_res_sr.ovf | w_res_si.ovf | w_res_dr.ovf | w_res_di.ovf;
    assign w_unused  = ^{w_res_sr.value[ACC_W-1:DATA_WIDTH], w_res_si.value[ACC_W-1:DATA_WIDTH],
                         w_res_dr.value[ACC_W-1:DATA_WIDTH], w_res_di.value[ACC_W-1:DATA_WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_out_r  <= '0;
            sum_out_i  <= '0;
            diff_out_r <= '0;
            diff_out_i <= '0;
            out_valid  <= 1'b0;
            ovf        <= 1'b0;
        end else if (en) begin
            sum_out_r  <= w_res_sr.value[DATA_WIDTH-1:0];
            sum_out_i  <= w_res_si.value[DATA_WIDTH-1:0];
            diff_out_r <= w_res_dr.value[DATA_WIDTH-1:0];
            diff_out_i <= w_res_di.value[DATA_WIDTH-1:0];
            out_valid  <= r_s2_v;
            ovf        <= r_s2_v & w_ovf_any;
        end
    end

    // Sticky rises with ovf on the same edge; a held ovf=1 blocks a clear.
    assign w_sticky_set = ovf | (en & r_s2_v & w_ovf_any);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= w_sticky_set | (ovf_sticky & ~ovf_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_butterfly_r2_pipe.sv
// ============================================================================
// Module  : tb_butterfly_r2_pipe
// Brief   : Directed self-checking bench for butterfly_r2_pipe (saturating and
//           wrapping instances share all inputs).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_butterfly_r2_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en, in_valid, scale, ovf_clr;
    logic signed [15:0] in1_r, in1_i, in2_r, in2_i, tw_r, tw_i;

    logic               out_valid, ovf, ovf_sticky;
    logic signed [15:0] sum_out_r, sum_out_i, diff_out_r, diff_out_i;
    logic               w_out_valid, w_ovf, w_ovf_sticky;
    logic signed [15:0] w_sum_out_r, w_sum_out_i, w_diff_out_r, w_diff_out_i;

    int errors = 0;
    int checks = 0;

    butterfly_r2_pipe #(.DATA_WIDTH(16), .TW_WIDTH(16), .SAT_EN(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .scale(scale),
        .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
        .tw_r(tw_r), .tw_i(tw_i), .ovf_clr(ovf_clr),
        .out_valid(out_valid), .sum_out_r(sum_out_r), .sum_out_i(sum_out_i),
        .diff_out_r(diff_out_r), .diff_out_i(diff_out_i),
        .ovf(ovf), .ovf_sticky(ovf_sticky)
    );

    butterfly_r2_pipe #(.DATA_WIDTH(16), .TW_WIDTH(16), .SAT_EN(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .scale(scale),
        .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
        .tw_r(tw_r), .tw_i(tw_i), .ovf_clr(ovf_clr),
        .out_valid(w_out_valid), .sum_out_r(w_sum_out_r), .sum_out_i(w_sum_out_i),
        .diff_out_r(w_diff_out_r), .diff_out_i(w_diff_out_i),
        .ovf(w_ovf), .ovf_sticky(w_ovf_sticky)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int twr, input int twi, input logic sc);
        in1_r = 16'(ar); in1_i = 16'(ai); in2_r = 16'(br); in2_i = 16'(bi);
        tw_r = 16'(twr); tw_i = 16'(twi); scale = sc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b0 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset ovf got %b/%b want 0/0", ovf, ovf_sticky); end
        checks++; if (sum_out_r !== 16'sd0 || diff_out_i !== 16'sd0) begin errors++; $display("FAIL reset data got %0d/%0d want 0/0", sum_out_r, diff_out_i); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_identity;
        send(1000, 0, 200, 0, 32767, 0, 1'b0);
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL identity out_valid got %b want 1", out_valid); end
        checks++; if (sum_out_r !== 16'sd1200 || sum_out_i !== 16'sd0) begin errors++; $display("FAIL identity sum got (%0d,%0d) want (1200,0)", sum_out_r, sum_out_i); end
        checks++; if (diff_out_r !== 16'sd800 || diff_out_i !== 16'sd0) begin errors++; $display("FAIL identity diff got (%0d,%0d) want (800,0)", diff_out_r, diff_out_i); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL identity ovf got %b want 0", ovf); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL identity pulse out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_minus_j;
        send(1000, 0, 200, 0, 0, -32768, 1'b0);
        step(); step();
        checks++; if (sum_out_r !== 16'sd1200 || sum_out_i !== 16'sd0) begin errors++; $display("FAIL minus_j sum got (%0d,%0d) want (1200,0)", sum_out_r, sum_out_i); end
        checks++; if (diff_out_r !== 16'sd0 || diff_out_i !== -16'sd800) begin errors++; $display("FAIL minus_j diff got (%0d,%0d) want (0,-800)", diff_out_r, diff_out_i); end
    endtask

    task automatic test_saturation;
        send(30000, 0, 10000, 0, 32767, 0, 1'b0);
        step(); step();
        checks++; if (sum_out_r !== 16'sd32767) begin errors++; $display("FAIL sat sum_r got %0d want 32767", sum_out_r); end
        checks++; if (ovf !== 1'b1 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat ovf/sticky got %b/%b want 1/1", ovf, ovf_sticky); end
        checks++; if (diff_out_r !== 16'sd19999 || diff_out_i !== 16'sd0) begin errors++; $display("FAIL sat diff got (%0d,%0d) want (19999,0)", diff_out_r, diff_out_i); end
        checks++; if (w_sum_out_r !== -16'sd25536) begin errors++; $display("FAIL wrap sum_r got %0d want -25536", w_sum_out_r); end
        checks++; if (w_ovf !== 1'b1) begin errors++; $display("FAIL wrap ovf got %b want 1", w_ovf); end
        step();
        checks++; if (ovf !== 1'b0 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat after ovf/sticky got %b/%b want 0/1", ovf, ovf_sticky); end
    endtask

    task automatic test_scaling;
        send(30000, 0, 10000, 0, 32767, 0, 1'b1);
        step(); step();
        checks++; if (sum_out_r !== 16'sd20000 || sum_out_i !== 16'sd0) begin errors++; $display("FAIL scale sum got (%0d,%0d) want (20000,0)", sum_out_r, sum_out_i); end
        checks++; if (diff_out_r !== 16'sd10000 || diff_out_i !== 16'sd0) begin errors++; $display("FAIL scale diff got (%0d,%0d) want (10000,0)", diff_out_r, diff_out_i); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL scale ovf got %b want 0", ovf); end
        send(3, 0, 0, 0, 32767, 0, 1'b1);
        step(); step();
        checks++; if (sum_out_r !== 16'sd2 || diff_out_r !== 16'sd1) begin errors++; $display("FAIL round pos got %0d/%0d want 2/1", sum_out_r, diff_out_r); end
        send(-3, 0, 0, 0, 32767, 0, 1'b1);
        step(); step();
        checks++; if (sum_out_r !== -16'sd1 || diff_out_r !== -16'sd1) begin errors++; $display("FAIL round neg got %0d/%0d want -1/-1", sum_out_r, diff_out_r); end
    endtask

    task automatic test_back_to_back;
        logic signed [15:0] esr [8];
        logic signed [15:0] esi [8];
        logic signed [15:0] edr [8];
        logic signed [15:0] edi [8];
        int got;
        got = 0;
        // tw ~ +1 with |a-b| < 2^14 leaves the difference exact
        for (int k = 0; k < 8; k++) begin
            esr[k] = 16'(100 * (k + 1) + 10 * k);
            esi[k] = 16'(-50 * k + 7);
            edr[k] = 16'(100 * (k + 1) - 10 * k);
            edi[k] = 16'(-50 * k - 7);
        end
        fork
            begin
                int k;
                k = 0;
                for (int c = 0; c < 10; c++) begin
                    en = (c != 4 && c != 5);
                    in_valid = 1'b1; scale = 1'b0; tw_r = 16'sd32767; tw_i = 16'sd0;
                    in1_r = 16'(100 * (k + 1)); in1_i = 16'(-50 * k);
                    in2_r = 16'(10 * k);        in2_i = 16'sd7;
                    step();
                    if (c != 4 && c != 5) k++;
                end
                in_valid = 1'b0;
                en = 1'b1;
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    logic e;
                    @(posedge clk);
                    e = en;
                    #1;
                    if (e) begin
                        if (out_valid === 1'b1) begin
                            if (got < 8) begin
                                checks++; if (sum_out_r !== esr[got] || sum_out_i !== esi[got]) begin errors++; $display("FAIL stream sum[%0d] got (%0d,%0d) want (%0d,%0d)", got, sum_out_r, sum_out_i, esr[got], esi[got]); end
                                checks++; if (diff_out_r !== edr[got] || diff_out_i !== edi[got]) begin errors++; $display("FAIL stream diff[%0d] got (%0d,%0d) want (%0d,%0d)", got, diff_out_r, diff_out_i, edr[got], edi[got]); end
                            end
                            got++;
                        end
                    end else begin
                        checks++;
                        if (!(got > 0 && out_valid === 1'b1 && sum_out_r === esr[got-1] && diff_out_i === edi[got-1])) begin
                            errors++; $display("FAIL stall hold got valid=%b sum_r=%0d want valid=1 held result %0d", out_valid, sum_out_r, got - 1);
                        end
                    end
                end
            end
        join
        checks++; if (got !== 8) begin errors++; $display("FAIL stream count got %0d want 8", got); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream drained out_valid got %b want 0", out_valid); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky hold got %b want 1", ovf_sticky); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0 || w_ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky clear got %b/%b want 0/0", ovf_sticky, w_ovf_sticky); end
    endtask

    task automatic test_reset_midflight;
        send(1000, 0, 200, 0, 32767, 0, 1'b0);
        send(500, 0, 100, 0, 32767, 0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || sum_out_r !== 16'sd0 || diff_out_r !== 16'sd0) begin errors++; $display("FAIL midreset outputs got valid=%b sum=%0d diff=%0d want 0", out_valid, sum_out_r, diff_out_r); end
        step();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset ghost cycle %0d out_valid got %b want 0", c, out_valid); end
        end
        send(5, 0, 1, 0, 32767, 0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset early out_valid got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || sum_out_r !== 16'sd6 || diff_out_r !== 16'sd4) begin errors++; $display("FAIL midreset new got valid=%b sum=%0d diff=%0d want 1/6/4", out_valid, sum_out_r, diff_out_r); end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; scale = 1'b0; ovf_clr = 1'b0;
        in1_r = '0; in1_i = '0; in2_r = '0; in2_i = '0; tw_r = '0; tw_i = '0;
        #1;
        test_reset();
        test_identity();
        test_minus_j();
        test_saturation();
        test_scaling();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
